// File: rtl/prio_scan_enc.sv
// Sequential priority scanner: accepts a request vector and emits its set indices highest-first, one per beat.
// Optional PRIO_SCAN_COUNT_EN adds out_cnt, the number of beats remaining in the current vector.
module prio_scan_enc #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             zero_seen,
`ifdef PRIO_SCAN_COUNT_EN
  output logic [IDXW:0]    out_cnt,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             scan;

  function automatic logic [IDXW-1:0] top_index(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = IDXW'(i);
    return idx;
  endfunction

`ifdef PRIO_SCAN_COUNT_EN
  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDXW:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++)
      n = n + (IDXW+1)'(v[i]);
    return n;
  endfunction

  // pend is always zero outside SCAN, so the count naturally reads 0 there.
  assign out_cnt = popcount(pend);
`endif

  assign scan      = (state == SCAN);
  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = scan;
  assign busy      = scan;
  assign out_idx   = scan ? top_index(pend) : '0;
  // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
  assign out_last  = scan && (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      zero_seen <= 1'b0;
    end else begin
      zero_seen <= 1'b0;
      if (flush) begin
        state <= IDLE;
        pend  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              if (in_vec != '0) begin
                pend  <= in_vec;
                state <= SCAN;
              end else begin
                zero_seen <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (out_ready) begin
              pend <= pend & ~(WIDTH'(1) << out_idx);
              if (out_last) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prio_scan_enc.sv
// Bench for prio_scan_enc: WIDTH=8 and WIDTH=5 instances checked every cycle against a queue-of-indices model.
module tb_prio_scan_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] vec8;
  logic [4:0] vec5;
  logic       ir8, ov8, ol8, zs8, bz8;
  logic       ir5, ov5, ol5, zs5, bz5;
  logic [2:0] idx8, idx5;
`ifdef PRIO_SCAN_COUNT_EN
  logic [3:0] cnt8, cnt5;
`endif

  prio_scan_enc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
    .in_vec(vec8), .out_valid(ov8), .out_ready(out_ready), .out_idx(idx8),
    .out_last(ol8), .zero_seen(zs8),
`ifdef PRIO_SCAN_COUNT_EN
    .out_cnt(cnt8),
`endif
    .busy(bz8));

  prio_scan_enc #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir5),
    .in_vec(vec5), .out_valid(ov5), .out_ready(out_ready), .out_idx(idx5),
    .out_last(ol5), .zero_seen(zs5),
`ifdef PRIO_SCAN_COUNT_EN
    .out_cnt(cnt5),
`endif
    .busy(bz5));

  int errors = 0;
  int checks = 0;

  typedef int iq_t[$];
  iq_t q8, q5;
  bit  zm8, zm5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending indices of a vector in service order (highest first).
  function automatic iq_t expand(input int v, input int w);
    iq_t q;
    q = {};
    for (int i = w - 1; i >= 0; i--)
      if ((v >> i) & 1) q.push_back(i);
    return q;
  endfunction

  // Called at a posedge: drive inputs, check outputs at the negedge, advance the model.
  task automatic step(input bit v, input logic [7:0] a, input logic [4:0] b,
                      input bit r, input bit f);
    #1;
    in_valid = v; vec8 = a; vec5 = b; out_ready = r; flush = f;
    @(negedge clk);
    chk("ov8",   ov8,  q8.size() > 0);
    chk("idx8",  idx8, q8.size() > 0 ? q8[0] : 0);
    chk("last8", ol8,  q8.size() == 1);
    chk("busy8", bz8,  q8.size() > 0);
    chk("ir8",   ir8,  (q8.size() == 0) && !f);
    chk("zs8",   zs8,  zm8);
    chk("ov5",   ov5,  q5.size() > 0);
    chk("idx5",  idx5, q5.size() > 0 ? q5[0] : 0);
    chk("last5", ol5,  q5.size() == 1);
    chk("busy5", bz5,  q5.size() > 0);
    chk("ir5",   ir5,  (q5.size() == 0) && !f);
    chk("zs5",   zs5,  zm5);
    chk("idx5_range", idx5 <= 3'd4, 1);
`ifdef PRIO_SCAN_COUNT_EN
    chk("cnt8", cnt8, q8.size());
    chk("cnt5", cnt5, q5.size());
`endif
    zm8 = 0;
    if (f) q8.delete();
    else if (q8.size() == 0) begin
      if (v) begin
        if (a != 0) q8 = expand(a, 8);
        else zm8 = 1;
      end
    end else if (r) void'(q8.pop_front());
    zm5 = 0;
    if (f) q5.delete();
    else if (q5.size() == 0) begin
      if (v) begin
        if (b != 0) q5 = expand(b, 5);
        else zm5 = 1;
      end
    end else if (r) void'(q5.pop_front());
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vec8 = '0; vec5 = '0;
    q8 = {}; q5 = {}; zm8 = 0; zm5 = 0;
    #2;
    chk("rst_ov8", ov8, 0);   chk("rst_idx8", idx8, 0); chk("rst_last8", ol8, 0);
    chk("rst_busy8", bz8, 0); chk("rst_zs8", zs8, 0);   chk("rst_ir8", ir8, 1);
    chk("rst_ov5", ov5, 0);   chk("rst_ir5", ir5, 1);
    #5 rst_n = 1'b1;
    @(posedge clk);

    // 8'hA5 drained with continuous ready
    step(1, 8'hA5, 5'h00, 1, 0);
    repeat (5) step(0, 8'h00, 5'h00, 1, 0);

    // 8'h81 with consumer stalled for three cycles
    step(1, 8'h81, 5'h00, 0, 0);
    repeat (3) step(0, 8'h00, 5'h00, 0, 0);
    repeat (3) step(0, 8'h00, 5'h00, 1, 0);

    // all-zero vector
    step(1, 8'h00, 5'h00, 1, 0);
    repeat (2) step(0, 8'h00, 5'h00, 1, 0);

    // 8'hFF flushed after two beats, then 8'h02
    step(1, 8'hFF, 5'h1F, 1, 0);
    repeat (2) step(0, 8'h00, 5'h00, 1, 0);
    step(0, 8'h00, 5'h00, 1, 1);
    step(1, 8'h02, 5'h00, 1, 0);
    repeat (2) step(0, 8'h00, 5'h00, 1, 0);

    // asynchronous reset in the middle of 8'hF0
    step(1, 8'hF0, 5'h0C, 1, 0);
    step(0, 8'h00, 5'h00, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov8", ov8, 0);   chk("arst_busy8", bz8, 0); chk("arst_idx8", idx8, 0);
    chk("arst_last8", ol8, 0); chk("arst_ir8", ir8, 1);   chk("arst_ov5", ov5, 0);
    q8 = {}; q5 = {}; zm8 = 0; zm5 = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    repeat (2) step(0, 8'h00, 5'h00, 1, 0);

    // WIDTH=5: 10001 then 00110 back-to-back with in_valid held high
    step(1, 8'h00, 5'b10001, 1, 0);
    repeat (5) step(1, 8'h00, 5'b00110, 1, 0);
    repeat (2) step(0, 8'h00, 5'h00, 1, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      logic [4:0] b;
      a = 8'($urandom);
      b = 5'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'h00;
      if ($urandom_range(0, 7) == 0) b = 5'h00;
      step(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
